// File: rtl/pdm_dac_array_if.sv
// pdm_dac_array_if
// Sample write bus for pdm_dac_array. The master presents one channel sample
// per transfer, and a transfer completes on an edge where valid and ready are both high.
//   i_wr_valid  master -> slave  write request
//   o_wr_ready  slave  -> master write may complete this cycle
//   i_wr_chan   master -> slave  target channel index
//   i_wr_data   master -> slave  sample, unsigned offset-binary
interface pdm_dac_array_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             i_wr_valid;
  logic             o_wr_ready;
  logic [CW-1:0]    i_wr_chan;
  logic [WIDTH-1:0] i_wr_data;

  modport master (output i_wr_valid, i_wr_chan, i_wr_data, input o_wr_ready);
  modport slave  (input i_wr_valid, i_wr_chan, i_wr_data, output o_wr_ready);
endinterface

// File: rtl/pdm_dac_array.sv
// pdm_dac_array
// Multi-channel sigma-delta PDM DAC. The design writes samples into per-channel
// shadow registers. A commit copies every shadow register into the active
// registers in the same cycle. Each channel has its own 1st- or 2nd-order
// modulator, and all modulators advance on the shared clock enable.
//   i_clk     system clock
//   i_res     synchronous active-low reset
//   i_ce      modulator clock enable
//   bus       sample write bus (slave side of pdm_dac_array_if)
//   i_commit  shadow -> active transfer, write-through for a same-cycle write
//   i_mute    substitute MUTE_CODE for every channel input
//   o_dac     one PDM bit per channel
//   o_err     sticky flag for a write to a channel index that does not exist
//   o_sat     one-cycle pulse when any 2nd-order integrator clipped
module pdm_dac_array #(
  parameter int              CHANNELS  = 2,
  parameter int              WIDTH     = 16,
  parameter int              ORDER     = 2,
  parameter int              GUARD     = 4,
  parameter logic [WIDTH-1:0] MUTE_CODE = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic                i_clk,
  input  logic                i_res,
  input  logic                i_ce,
  pdm_dac_array_if.slave      bus,
  input  logic                i_commit,
  input  logic                i_mute,
  output logic [CHANNELS-1:0] o_dac,
  output logic                o_err,
  output logic                o_sat
);

  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NSLOT = 2 ** CW;

  // The channel field can encode more indices than there are channels.
  // This table marks which encodings are real channels.
  function automatic logic [NSLOT-1:0] chan_ok_mask();
    logic [NSLOT-1:0] m;
    for (int i = 0; i < NSLOT; i++) m[i] = (i < CHANNELS);
    return m;
  endfunction
  localparam logic [NSLOT-1:0] CHAN_OK = chan_ok_mask();

  logic                r_rdy_arm;
  logic                r_wr_ready;
  logic                r_err;
  logic                r_sat;
  logic [CHANNELS-1:0] r_dac;
  logic [WIDTH-1:0]    r_shadow [CHANNELS];
  logic [WIDTH-1:0]    r_active [CHANNELS];

  logic                w_wr_fire;
  logic                w_chan_ok;
  logic [CHANNELS-1:0] w_wr_hit;
  logic [CHANNELS-1:0] w_dac_next;
  logic [CHANNELS-1:0] w_sat_ch;

  assign w_wr_fire = bus.i_wr_valid & r_wr_ready;
  assign w_chan_ok = CHAN_OK[bus.i_wr_chan];

  always_comb begin
    w_wr_hit = '0;
    for (int k = 0; k < CHANNELS; k++)
      w_wr_hit[k] = w_wr_fire & w_chan_ok & (bus.i_wr_chan == CW'(k));
  end

  // Ready is held low for the reset cycle and for one further cycle after
  // reset is released.
  always_ff @(posedge i_clk) begin
    if (!i_res) begin
      r_rdy_arm  <= 1'b0;
      r_wr_ready <= 1'b0;
    end else begin
      r_rdy_arm  <= 1'b1;
      r_wr_ready <= r_rdy_arm;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_res) begin
      r_err <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
    end else begin
      if (w_wr_fire && !w_chan_ok) r_err <= 1'b1;
      for (int k = 0; k < CHANNELS; k++) begin
        if (w_wr_hit[k]) r_shadow[k] <= bus.i_wr_data;
        if (i_commit)    r_active[k] <= w_wr_hit[k] ? bus.i_wr_data : r_shadow[k];
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [WIDTH-1:0] w_x;
    assign w_x = i_mute ? MUTE_CODE : r_active[k];

    if (ORDER == 1) begin : g_o1
      logic [WIDTH-1:0] r_acc;
      logic [WIDTH:0]   w_sum;
      assign w_sum = {1'b0, r_acc} + {1'b0, w_x};

      always_ff @(posedge i_clk) begin
        if (!i_res)    r_acc <= '0;
        else if (i_ce) r_acc <= w_sum[WIDTH-1:0];
      end

      assign w_dac_next[k] = w_sum[WIDTH];
      assign w_sat_ch[k]   = 1'b0;
    end else if (ORDER == 2) begin : g_o2
      localparam int IW = WIDTH + GUARD + 2;
      // The sums are 2 bits wider than the integrators, so the sum of three
      // terms cannot wrap before the clip compares it with the limits.
      localparam int SW = IW + 2;
      localparam logic signed [SW-1:0] LIM_HI = {3'b000, {(IW-1){1'b1}}};
      localparam logic signed [SW-1:0] LIM_LO = {3'b111, {(IW-1){1'b0}}};
      localparam logic signed [SW-1:0] FB     =
        {{(SW-WIDTH-1){1'b0}}, 1'b1, {WIDTH{1'b0}}};

      logic signed [IW-1:0] r_i1, r_i2;
      logic signed [SW-1:0] w_x_ext, w_fb, w_s1, w_s2;
      logic signed [IW-1:0] w_i1n, w_i2n;
      logic                 w_hi1, w_lo1, w_hi2, w_lo2;

      assign w_x_ext = signed'({{(SW-WIDTH){1'b0}}, w_x});
      assign w_fb    = r_dac[k] ? FB : '0;

      assign w_s1  = signed'({{2{r_i1[IW-1]}}, r_i1}) + w_x_ext - w_fb;
      assign w_hi1 = (w_s1 > LIM_HI);
      assign w_lo1 = (w_s1 < LIM_LO);
      assign w_i1n = w_hi1 ? LIM_HI[IW-1:0] : (w_lo1 ? LIM_LO[IW-1:0] : w_s1[IW-1:0]);

      assign w_s2  = signed'({{2{r_i2[IW-1]}}, r_i2}) + signed'({{2{w_i1n[IW-1]}}, w_i1n}) - w_fb;
      assign w_hi2 = (w_s2 > LIM_HI);
      assign w_lo2 = (w_s2 < LIM_LO);
      assign w_i2n = w_hi2 ? LIM_HI[IW-1:0] : (w_lo2 ? LIM_LO[IW-1:0] : w_s2[IW-1:0]);

      always_ff @(posedge i_clk) begin
        if (!i_res) begin
          r_i1 <= '0;
          r_i2 <= '0;
        end else if (i_ce) begin
          r_i1 <= w_i1n;
          r_i2 <= w_i2n;
        end
      end

      // The compare is strictly greater than zero, so a zero input gives a
      // constant-zero bitstream.
      assign w_dac_next[k] = !w_i2n[IW-1] && (w_i2n != '0);
      assign w_sat_ch[k]   = w_hi1 | w_lo1 | w_hi2 | w_lo2;
    end else begin : g_bad_order
      $error("pdm_dac_array: ORDER must be 1 or 2");
      assign w_dac_next[k] = 1'b0;
      assign w_sat_ch[k]   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_res) begin
      r_dac <= '0;
      r_sat <= 1'b0;
    end else begin
      r_sat <= i_ce & (|w_sat_ch);
      if (i_ce) r_dac <= w_dac_next;
    end
  end

  assign bus.o_wr_ready = r_wr_ready;
  assign o_dac          = r_dac;
  assign o_err          = r_err;
  assign o_sat          = r_sat;

endmodule
